// File: rtl/tt_um_uwasic_mhanson_spi.sv
`default_nettype none
// ============================================================================
//  Module   : tt_um_uwasic_mhanson_spi
//  Purpose  : SPI mode-0 write-only register bank driving 16 PWM-capable
//             outputs. A shared 8-bit duty cycle, with per-channel output
//             enable and PWM select.
//  Revision : 1.0  initial release
// ============================================================================
module tt_um_uwasic_mhanson_spi (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam logic [3:0] C_DIV_LAST   = 4'd12;
    localparam logic [4:0] C_FRAME_BITS = 5'd16;
    localparam logic [6:0] C_ADDR_MAX   = 7'd4;

    // Synchroniser chains; the third stage on SCLK and nCS gives edge detection
    logic [2:0]  r_sclk_sync;
    logic [1:0]  r_copi_sync;
    logic [2:0]  r_ncs_sync;

    // Frame capture state
    logic [4:0]  r_bit_cnt;
    logic [15:0] r_shift;

    // Register bank
    logic [15:0] r_en_out;
    logic [15:0] r_en_pwm;
    logic [7:0]  r_duty;

    // PWM timebase
    logic [3:0]  r_div;
    logic [7:0]  r_pwm_cnt;
    logic [15:0] r_out;

    logic        w_sclk_rise;
    logic        w_ncs_fall;
    logic        w_ncs_rise;
    logic        w_ncs_low;
    logic        w_commit;
    logic        w_pwm;
    logic        w_unused;

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_ncs_fall  = ~r_ncs_sync[1] & r_ncs_sync[2];
    assign w_ncs_rise  = r_ncs_sync[1] & ~r_ncs_sync[2];
    assign w_ncs_low   = ~r_ncs_sync[1];

    // Only complete write frames addressed inside the map are committed
    assign w_commit = w_ncs_rise && (r_bit_cnt == C_FRAME_BITS) &&
                      r_shift[15] && (r_shift[14:8] <= C_ADDR_MAX);

    // Full duty forces a constant high, otherwise a plain compare
    assign w_pwm = (r_duty == 8'hFF) ? 1'b1 : (r_pwm_cnt < r_duty);

    assign uo_out   = r_out[7:0];
    assign uio_out  = r_out[15:8];
    assign uio_oe   = 8'hFF;
    assign w_unused = &{1'b0, ena, uio_in, ui_in[7:3]};

    // Bring the asynchronous SPI pins into the clk domain
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_sclk_sync <= 3'b000;
            r_copi_sync <= 2'b00;
            r_ncs_sync  <= 3'b000;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], ui_in[0]};
            r_copi_sync <= {r_copi_sync[0], ui_in[1]};
            r_ncs_sync  <= {r_ncs_sync[1:0], ui_in[2]};
        end
    end

    // Shift in up to 16 COPI bits per frame; later edges are ignored
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_bit_cnt <= 5'd0;
            r_shift   <= 16'h0000;
        end else if (w_ncs_fall) begin
            r_bit_cnt <= 5'd0;
            r_shift   <= 16'h0000;
        end else if (w_ncs_low && w_sclk_rise && (r_bit_cnt < C_FRAME_BITS)) begin
            r_bit_cnt <= r_bit_cnt + 5'd1;
            r_shift   <= {r_shift[14:0], r_copi_sync[1]};
        end
    end

    // Commit a valid frame into the register map on nCS release
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_en_out <= 16'h0000;
            r_en_pwm <= 16'h0000;
            r_duty   <= 8'h00;
        end else if (w_commit) begin
            case (r_shift[10:8])
                3'd0:    r_en_out[7:0]  <= r_shift[7:0];
                3'd1:    r_en_out[15:8] <= r_shift[7:0];
                3'd2:    r_en_pwm[7:0]  <= r_shift[7:0];
                3'd3:    r_en_pwm[15:8] <= r_shift[7:0];
                default: r_duty         <= r_shift[7:0];
            endcase
        end
    end

    // Divide by 13, then advance the free-running 8-bit PWM counter
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_div     <= 4'd0;
            r_pwm_cnt <= 8'd0;
        end else if (r_div == C_DIV_LAST) begin
            r_div     <= 4'd0;
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end else begin
            r_div     <= r_div + 4'd1;
        end
    end

    // Registered channel outputs: disabled -> 0, enabled -> PWM or static 1
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_out <= 16'h0000;
        end else begin
            r_out <= r_en_out & (~r_en_pwm | {16{w_pwm}});
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tt_um_uwasic_mhanson_spi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tt_um_uwasic_mhanson_spi
//  Purpose  : Directed self-checking bench for the SPI PWM tile.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tt_um_uwasic_mhanson_spi;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;
    int hi_t;
    int per_t;
    int cnt;

    tt_um_uwasic_mhanson_spi dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert ((obs >= lo) && (obs <= hi)) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Send the top nbits of a 16-bit word, MSB first, mode 0
    task automatic spi_frame(input logic [15:0] w, input int nbits);
        ui_in[2] = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            ui_in[1] = w[15-i];
            repeat (6) @(negedge clk);
            ui_in[0] = 1'b1;
            repeat (6) @(negedge clk);
            ui_in[0] = 1'b0;
        end
        repeat (6) @(negedge clk);
        ui_in[2] = 1'b1;
        ui_in[1] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // High time and rise-to-rise period of uo_out[0], bounded
    task automatic measure(output int hi, output int per);
        int n;
        n = 0;
        hi = 0;
        while (uo_out[0] !== 1'b0 && n < 8000) begin @(negedge clk); n++; end
        while (uo_out[0] !== 1'b1 && n < 8000) begin @(negedge clk); n++; end
        while (uo_out[0] === 1'b1 && hi < 8000) begin @(negedge clk); hi++; end
        per = hi;
        while (uo_out[0] === 1'b0 && per < 8000) begin @(negedge clk); per++; end
    endtask

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'b0000_0100;
        uio_in = 8'h00;
        repeat (5) @(negedge clk);
        chk("reset_uo_out", {24'd0, uo_out}, 32'h00);
        chk("reset_uio_out", {24'd0, uio_out}, 32'h00);
        chk("reset_uio_oe", {24'd0, uio_oe}, 32'hFF);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);

        // Static enables
        spi_frame(16'h80F0, 16);
        spi_frame(16'h81CC, 16);
        chk("write_en_out_lo", {24'd0, uo_out}, 32'hF0);
        chk("write_en_out_hi", {24'd0, uio_out}, 32'hCC);
        repeat (500) @(negedge clk);
        chk("static_uo_out", {24'd0, uo_out}, 32'hF0);
        chk("static_uio_out", {24'd0, uio_out}, 32'hCC);

        // Out-of-map write, read frame, first address past the map
        spi_frame(16'hB0FF, 16);
        spi_frame(16'h00FF, 16);
        spi_frame(16'h85FF, 16);
        chk("ignored_uo_out", {24'd0, uo_out}, 32'hF0);
        chk("ignored_uio_out", {24'd0, uio_out}, 32'hCC);

        // Truncated frame discarded, next full frame accepted
        spi_frame(16'h8000, 10);
        chk("short_frame", {24'd0, uo_out}, 32'hF0);
        spi_frame(16'h8001, 16);
        chk("after_short", {24'd0, uo_out}, 32'h01);

        // PWM on channels 0 and 1; channel 1 disabled so stays low, duty 0
        spi_frame(16'h8203, 16);
        chk("pwm_duty0_sel", {24'd0, uo_out}, 32'h00);

        // 50% duty
        spi_frame(16'h8480, 16);
        measure(hi_t, per_t);
        chk_range("duty80_high", hi_t, 1651, 1677);
        chk_range("duty80_period", per_t, 3327, 3329);

        // Smallest nonzero duty: one counter step high
        spi_frame(16'h8401, 16);
        measure(hi_t, per_t);
        chk_range("duty01_high", hi_t, 12, 14);
        chk_range("duty01_period", per_t, 3327, 3329);

        // Duty 0 -> constant low over two periods
        spi_frame(16'h8400, 16);
        cnt = 0;
        for (int i = 0; i < 6700; i++) begin
            @(negedge clk);
            if (uo_out[0] === 1'b1) cnt++;
        end
        chk("duty00_high_samples", cnt, 0);

        // Duty FF -> constant high over two periods; channel 1 still off
        spi_frame(16'h84FF, 16);
        cnt = 0;
        for (int i = 0; i < 6700; i++) begin
            @(negedge clk);
            if (uo_out[0] !== 1'b1) cnt++;
        end
        chk("dutyFF_low_samples", cnt, 0);
        chk("dutyFF_uo_out", {24'd0, uo_out}, 32'h01);
        chk("dutyFF_uio_out", {24'd0, uio_out}, 32'hCC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_um_uwasic_mhanson_spi.md
# tt_um_uwasic_mhanson_spi

Top-level user tile combining an SPI-mode-0 write-only register bank with a 16-channel PWM output stage. An external SPI controller drives `ui_in`. The controller writes five 8-bit registers that enable outputs, select PWM per channel, and set a shared duty cycle. The 16 outputs appear on `{uio_out, uo_out}` at about 3 kHz from a 10 MHz system clock.

## Interface
- No parameters. Internal constants: clock-divider terminal count 12; PWM counter width 8.
- `clk` input 1: system clock, nominally 10 MHz.
- `rst_n` input 1: one clock; reset is asynchronous and active-high. Asserted when 1; clears all state immediately.
- `ena` input 1: tile select. Ignored functionally.
- `ui_in` input 8:
  - [0] SCLK.
  - [1] COPI.
  - [2] nCS, active-low.
  - [7:3] unused.
- `uio_in` input 8: unused.
- `uo_out` output 8: channel outputs 7..0.
- `uio_out` output 8: channel outputs 15..8.
- `uio_oe` output 8: constant 8'hFF.

## Operation
- Input synchronisers:
  - SCLK, COPI and nCS each pass through a 2-flop synchroniser.
  - A third SCLK flop provides rising-edge detection.
- SPI frame format:
  - Mode 0, MSB first, 16 bits.
  - Bit 15 is R/W (1 = write).
  - Bits 14:8 are the 7-bit address.
  - Bits 7:0 are the data.
- Frame capture:
  - nCS falling clears the 5-bit bit counter and the shift register.
  - While nCS is low, each synchronised SCLK rising edge shifts COPI in, up to 16 bits.
  - Edges after the 16th are ignored.
- Commit on synchronised nCS rising edge. A write occurs only when all of the following hold; otherwise the frame is discarded with no state change:
  - bit count == 16;
  - R/W == 1;
  - address ≤ 0x04.
- Register map (all reset to 0x00):
  - 0x00 `en_out[7:0]`
  - 0x01 `en_out[15:8]`
  - 0x02 `en_pwm[7:0]`
  - 0x03 `en_pwm[15:8]`
  - 0x04 `duty[7:0]`
- Reads (R/W = 0) are unsupported; COPI data is ignored and there is no CIPO.
- PWM timebase:
  - A divider counts 0..12 and wraps, producing a tick every 13 clk.
  - On each tick, an 8-bit counter increments and wraps 255→0.
  - Period = 13×256 = 3328 clk, ≈ 3004.8 Hz at 10 MHz.
- PWM signal:
  - `pwm = (duty == 8'hFF) ? 1 : (counter < duty)`.
  - duty 0x00 gives constant 0; duty 0xFF gives constant 1.
  - High time = duty × 13 clk per period.
- Per channel i:
  - `out[i] = en_out[i] ? (en_pwm[i] ? pwm : 1) : 0`.
  - `en_pwm` has no effect when `en_out` is 0.
- Output mapping: `{uio_out, uo_out} = out[15:0]`.

## Timing
- Reset: all outputs 0 except `uio_oe` = 0xFF. Registers, counters, synchronisers and shift state are all cleared.
- SPI edge latency: 3 clk from SCLK pin edge to sample. Required SCLK high and low times ≥ 4 clk each; nCS setup and hold ≥ 4 clk.
- Register update: visible on outputs within 4 clk of the nCS pin rising edge.
- Duty change mid-period: takes effect immediately in the compare, with no double buffering.
- Reset mid-frame: frame discarded; the next nCS falling starts cleanly.
- nCS rising with fewer than 16 bits: discard. Back-to-back frames are allowed after nCS has been high ≥ 4 clk.

## Test plan
- Reset -> `uo_out` = 0x00, `uio_out` = 0x00, `uio_oe` = 0xFF.
- Write 0x00←0xF0 then 0x01←0xCC -> `uo_out` = 0xF0, `uio_out` = 0xCC, static.
- Write to address 0x30 and a read frame (R/W = 0) to 0x00 -> all register contents and outputs unchanged.
- Write `en_out[7:0]` = 0x01, `en_pwm[7:0]` = 0x01, duty 0x80 -> `uo_out[0]` period 3328±1 clk (≈3 kHz), high 1664±13 clk (50%).
- Duty 0x00 -> `uo_out[0]` constant 0; duty 0xFF -> constant 1 over ≥2 periods.
- nCS raised after 10 bits of a write to 0x00 -> `uo_out` unchanged. A following valid full frame is accepted.
